// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the multi-cycle add/subtract sequencer.
// Holds the FSM state encoding, default geometry and the word-counter width helper.
package addsub_seq_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_NWORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter needs at least one bit, even when a single pass suffices.
  function automatic int cnt_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Command/result bundle for addsub_seq; ovf exists only with ADDSUB_SEQ_OVF_EN.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface addsub_seq_if
  import addsub_seq_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int NWORDS = DEF_NWORDS
);
  localparam int DW = WORD_W * NWORDS;

  logic          in_valid;
  logic          in_ready;
  logic          op_sub;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          cout;
  logic          busy;
`ifdef ADDSUB_SEQ_OVF_EN
  logic          ovf;
`endif

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, busy
`ifdef ADDSUB_SEQ_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, busy
`ifdef ADDSUB_SEQ_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/addsub_slice.sv
// Combinational W-bit adder slice shared across all word passes.
// With ADDSUB_SEQ_OVF_EN it also exposes the carry into the MSB for signed overflow.
module addsub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
`ifdef ADDSUB_SEQ_OVF_EN
  , output logic       c_msb
`endif
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s    = full[W-1:0];
  assign cout = full[W];

`ifdef ADDSUB_SEQ_OVF_EN
  // Sum bit = a ^ b ^ carry_in, so the MSB carry-in falls out of the result bit.
  assign c_msb = a[W-1] ^ b[W-1] ^ full[W-1];
`endif

endmodule

// File: rtl/addsub_seq.sv
// Wide add/subtract sequencer: one WORD_W slice, NWORDS passes LSW first, carry registered.
// Optional signed overflow output is compiled in with ADDSUB_SEQ_OVF_EN.
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int NWORDS = DEF_NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  addsub_seq_if.slave  bus,
  output state_e       state_o
);

  localparam int DW    = WORD_W * NWORDS;
  localparam int CNT_W = cnt_width(NWORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     b_q, b_d;
  logic [DW-1:0]     sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              in_ready_q, out_valid_q, busy_q;
  logic              accept;
  int                base;
  logic [WORD_W-1:0] a_word, b_word, s_word;
  logic              c_word;
`ifdef ADDSUB_SEQ_OVF_EN
  logic              ovf_q, ovf_d;
  logic              c_msb;
`endif

  assign accept = bus.in_valid & in_ready_q;
  assign base   = int'(cnt_q) * WORD_W;
  assign a_word = a_q[base +: WORD_W];
  assign b_word = b_q[base +: WORD_W];

  addsub_slice #(.W(WORD_W)) u_slice (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .s    (s_word),
    .cout (c_word)
`ifdef ADDSUB_SEQ_OVF_EN
    , .c_msb (c_msb)
`endif
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDSUB_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Subtract is a + ~b + 1; the +1 enters only through the preloaded carry.
          a_d     = bus.a;
          b_d     = bus.op_sub ? ~bus.b : bus.b;
          carry_d = bus.op_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: WORD_W] = s_word;
        carry_d = c_word;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = c_word;
`ifdef ADDSUB_SEQ_OVF_EN
          ovf_d   = c_msb ^ c_word;
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
`ifdef ADDSUB_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;
`ifdef ADDSUB_SEQ_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
  assign state_o       = state_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq (WORD_W=16, NWORDS=4); ovf checked when ADDSUB_SEQ_OVF_EN is defined.
// Expected results are queued at command time and compared when the result handshake happens.
module tb_addsub_seq;
  import addsub_seq_pkg::*;

  localparam int WORD_W = 16;
  localparam int NWORDS = 4;
  localparam int DW     = WORD_W * NWORDS;

  logic   clk;
  logic   rst;
  state_e dut_state;
  int     n_cmp;
  int     n_err;

  // Packed expectation: {ovf, cout, sum}
  logic [DW+1:0] exp_q[$];

  addsub_seq_if #(.WORD_W(WORD_W), .NWORDS(NWORDS)) bus ();

  addsub_seq #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dut_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Independent reference: plain wide add, or difference with borrow test.
  function automatic logic [DW+1:0] model(input logic op, input logic [DW-1:0] av,
                                          input logic [DW-1:0] bv);
    logic [DW:0]   wide;
    logic [DW-1:0] s;
    logic          c, v;
    if (op) begin
      s = av - bv;
      c = (av >= bv);
      v = (av[DW-1] != bv[DW-1]) && (s[DW-1] != av[DW-1]);
    end else begin
      wide = {1'b0, av} + {1'b0, bv};
      s = wide[DW-1:0];
      c = wide[DW];
      v = (av[DW-1] == bv[DW-1]) && (s[DW-1] != av[DW-1]);
    end
    return {v, c, s};
  endfunction

  // ---------------- result monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 128'(1), 128'(0));
      end else begin
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        check("sum", 128'(bus.sum), 128'(e[DW-1:0]));
        check("cout", 128'(bus.cout), 128'(e[DW]));
`ifdef ADDSUB_SEQ_OVF_EN
        check("ovf", 128'(bus.ovf), 128'(e[DW+1]));
`endif
      end
    end
  end

  // ---------------- drivers ----------------
  // Waits for in_ready, presents one command for one accepted cycle.
  task automatic send(input logic op, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                      input bit expect_result);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 128'(0), 128'(1));
      return;
    end
    bus.in_valid = 1'b1;
    bus.op_sub   = op;
    bus.a        = av;
    bus.b        = bv;
    if (expect_result) exp_q.push_back(model(op, av, bv));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Sends a command and checks that out_valid rises exactly NWORDS cycles after accept.
  task automatic run_op(input logic op, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    int cyc;
    send(op, av, bv, 1'b1);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 128'(cyc), 128'(NWORDS));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW+1:0] e;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_sum", 128'(bus.sum), 128'(0));
    check("rst_cout", 128'(bus.cout), 128'(0));
    check("rst_state", 128'(dut_state), 128'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));

    // Directed vectors
    run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
    idle_cycles(2);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    idle_cycles(2);
    run_op(1'b1, 64'h5, 64'h7);
    idle_cycles(2);
    run_op(1'b1, 64'h7, 64'h5);
    idle_cycles(2);
    run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    idle_cycles(2);
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'h1);
    idle_cycles(2);

    // Back-pressure in DONE while in_valid pulses
    bus.out_ready = 1'b0;
    e = model(1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
    run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 64'(i + 100);
      bus.b        = 64'(i + 200);
      @(posedge clk); #1;
      check("hold_sum", 128'(bus.sum), 128'(e[DW-1:0]));
      check("hold_cout", 128'(bus.cout), 128'(e[DW]));
      check("hold_in_ready", 128'(bus.in_ready), 128'(0));
      check("hold_out_valid", 128'(bus.out_valid), 128'(1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 128'(bus.in_ready), 128'(1));
    check("release_out_valid", 128'(bus.out_valid), 128'(0));
    idle_cycles(6);
    check("no_stray_busy", 128'(bus.busy), 128'(0));

    // Reset during the second RUN cycle
    send(1'b0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 128'(bus.out_valid), 128'(0));
    check("abort_sum", 128'(bus.sum), 128'(0));
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(8);
    check("abort_no_result", 128'(bus.out_valid), 128'(0));
    run_op(1'b0, 64'h3, 64'h4);
    idle_cycles(2);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] ra, rb;
      logic          rop;
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rop = 1'($urandom_range(0, 1));
      run_op(rop, ra, rb);
      idle_cycles(1);
    end

    idle_cycles(4);
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-cycle wide add/subtract sequencer built around one shared WORD_W-bit add/sub slice. Accepts a NWORDS×WORD_W operand pair plus an operation select over a valid/ready handshake, and feeds the slice one word per cycle, least-significant word first, with a registered carry between words. Presents the full-width result, carry-out and optional signed overflow over a second valid/ready handshake. Sits between a command source and a result consumer wherever a wide adder is too costly in area.

## Interface
- WORD_W, 16, width of the shared slice in bits
- NWORDS, 4, number of slice passes per operation (operand width = WORD_W*NWORDS)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready at clk edge
- op_sub  in  1  0 = a+b, 1 = a−b; sampled at accept
- a  in  WORD_W*NWORDS  operand A; sampled at accept
- b  in  WORD_W*NWORDS  operand B; sampled at accept
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready at clk edge
- sum  out  WORD_W*NWORDS  result
- cout  out  1  carry-out of MSW (for subtract: 1 = no borrow)
- ovf  out  1  signed overflow (present only with ADDSUB_SEQ_OVF_EN)
- busy  out  1  high in RUN or DONE

## Operation
- Reset values: in_ready=0 during rst and 1 after release; out_valid=0, sum=0, cout=0, ovf=0, busy=0; state IDLE; word counter 0; carry register 0.
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On accept, capture a, op_sub, and b_eff = op_sub ? ~b : b; preload carry = op_sub; counter = 0; go to RUN.
- RUN: in_ready=0. Each cycle the slice computes {c, s} = a_word[cnt] + b_eff_word[cnt] + carry; s is written to sum word cnt; carry ← c; cnt++. After the pass with cnt = NWORDS−1, cout ← c and state goes to DONE.
- DONE: out_valid=1; sum, cout and ovf are held stable until out_ready. On handshake go to IDLE with out_valid=0. in_valid is ignored in RUN and DONE.
- Arithmetic is modulo 2^(WORD_W*NWORDS). Subtraction is always a + ~b + 1, with the +1 applied only through the initial carry, never to b directly.
- NWORDS=1 is legal: RUN lasts one cycle.
- Reset mid-operation: all state and outputs return to reset values immediately. The partial result is discarded and no out_valid is produced for the aborted command.

## Timing
- Accept at edge E → RUN occupies edges E+1..E+NWORDS → out_valid is high after edge E+NWORDS (latency NWORDS cycles).
- Minimum issue interval is NWORDS+2 cycles, with out_ready held high: result handshake at edge E+NWORDS+1, in_ready high again after it.
- in_ready, out_valid and busy are registered state decodes. Only the slice is combinational, one word per cycle.

## Configuration
- ADDSUB_SEQ_OVF_EN defined: ovf port exists. In the final pass ovf ← carry_into_MSB XOR carry_out_of_MSB. It is registered with cout and held through DONE.
- ADDSUB_SEQ_OVF_EN undefined: no ovf port, no overflow logic.

## Structure
- Package addsub_seq_pkg holds the state enum (IDLE, RUN, DONE), the counter width $clog2(NWORDS) (minimum 1) and default WORD_W/NWORDS constants.
- Sub-module addsub_slice: combinational WORD_W adder with inputs a, b, cin and outputs s, cout, plus the carry into the MSB when the overflow feature is compiled in. Instantiated once.

## Test plan
Defaults WORD_W=16, NWORDS=4.
- Add 0x0000_0000_0000_FFFF + 0x1 → sum 0x0000_0000_0001_0000, cout 0, ovf 0; out_valid exactly 4 cycles after accept.
- Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 → sum 0, cout 1, ovf 0.
- Sub 0x5 − 0x7 → sum 0xFFFF_FFFF_FFFF_FFFE, cout 0, ovf 0; Sub 0x7 − 0x5 → sum 0x2, cout 1.
- Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 → sum 0x8000_0000_0000_0000, ovf 1 (with the macro), cout 0.
- Hold out_ready low for 3 cycles in DONE while pulsing in_valid → sum/cout stable, in_ready 0, no new command captured; 1 cycle after out_ready, in_ready=1.
- Assert rst at the 2nd RUN cycle → out_valid/sum/busy 0 immediately, no result emitted; a following add 0x3 + 0x4 returns 0x7.
